// File: rtl/hi_trace_trigger_pkg.sv
// Shared constants for the HF trace trigger: FPGA major-mode codes and trigger state encoding.
// Pure declarations; no logic or latency of its own.
package hi_trace_trigger_pkg;

    localparam logic [2:0] FPGA_MAJOR_MODE_HF_READER     = 3'd0;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_SIMULATOR  = 3'd1;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_ISO14443A  = 3'd2;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_SNIFF      = 3'd3;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_ISO18092   = 3'd4;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_GET_TRACE  = 3'd5;
    localparam logic [2:0] FPGA_MAJOR_MODE_HF_FSK_READER = 3'd6;
    localparam logic [2:0] FPGA_MAJOR_MODE_OFF           = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FULL   = 3'd4
    } trig_state_t;

    // Capture may run only when armed and the FPGA is not idle or reading the trace back out.
    function automatic logic trace_run(input logic arm, input logic [2:0] mode);
        return arm && (mode != FPGA_MAJOR_MODE_OFF) && (mode != FPGA_MAJOR_MODE_HF_GET_TRACE);
    endfunction

endpackage

// File: rtl/hi_trace_envelope.sv
// Sample-strobe divider plus per-window peak-to-peak detector on the raw ADC stream.
// Strobe is combinational from the divider; win_end/activity are registered one clock after the window's last strobe.
module hi_trace_envelope #(
    parameter int SAMPLE_DIV = 8,
    parameter int WIN_LEN    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_adc_d,
    input  logic [7:0] i_threshold,
    output logic       o_strobe,
    output logic       o_win_end,
    output logic       o_activity
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WIN_W = $clog2(WIN_LEN);

    logic [DIV_W-1:0] r_div;
    logic [WIN_W-1:0] r_win;
    logic [7:0]       r_min;
    logic [7:0]       r_max;
    logic             r_win_end;
    logic             r_activity;

    logic             w_strobe;
    logic [7:0]       w_min_n;
    logic [7:0]       w_max_n;
    logic [7:0]       w_span;

    assign w_strobe = (r_div == '0);
    assign w_min_n  = (i_adc_d < r_min) ? i_adc_d : r_min;
    assign w_max_n  = (i_adc_d > r_max) ? i_adc_d : r_max;
    assign w_span   = w_max_n - w_min_n;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div      <= '0;
            r_win      <= '0;
            r_min      <= 8'hFF;
            r_max      <= 8'h00;
            r_win_end  <= 1'b0;
            r_activity <= 1'b0;
        end else begin
            r_div      <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);
            r_win_end  <= 1'b0;
            r_activity <= 1'b0;
            if (w_strobe) begin
                if (r_win == WIN_W'(WIN_LEN - 1)) begin
                    // The closing sample also seeds the next window's extremes.
                    r_win      <= '0;
                    r_win_end  <= 1'b1;
                    r_activity <= (w_span >= i_threshold);
                    r_min      <= i_adc_d;
                    r_max      <= i_adc_d;
                end else begin
                    r_win <= r_win + WIN_W'(1);
                    r_min <= w_min_n;
                    r_max <= w_max_n;
                end
            end
        end
    end

    assign o_strobe   = w_strobe;
    assign o_win_end  = r_win_end;
    assign o_activity = r_activity;

endmodule

// File: rtl/hi_trace_trigger.sv
// Decides when the HF trace buffer should capture, based on windowed ADC activity, and tracks capture progress.
// trace_enable rises one clock after an active window ends; forced exit to IDLE one clock after run drops.
module hi_trace_trigger
    import hi_trace_trigger_pkg::*;
#(
    parameter int SAMPLE_DIV = 8,
    parameter int WIN_LEN    = 4,
    parameter int HOLD_WIN   = 16,
    parameter int DEPTH      = 3072
) (
    input  logic        ck_1356megb,
    input  logic        reset,
    input  logic [7:0]  adc_d,
    input  logic [2:0]  major_mode,
    input  logic        arm,
    input  logic        oneshot,
    input  logic [7:0]  threshold,
    output logic        trace_enable,
    output logic        trace_active,
    output logic        trace_full,
    output logic [11:0] sample_count
);

    localparam int          HOLD_W  = $clog2(HOLD_WIN + 1);
    localparam logic [11:0] DEPTH_C = 12'(DEPTH);

    trig_state_t       r_state;
    logic              r_enable;
    logic              r_active;
    logic              r_full;
    logic [11:0]       r_count;
    logic [HOLD_W-1:0] r_hold;

    logic              w_strobe;
    logic              w_win_end;
    logic              w_activity;
    logic              w_run;
    logic [11:0]       w_cnt_inc;
    logic              w_count_now;

    hi_trace_envelope #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .WIN_LEN    (WIN_LEN)
    ) u_envelope (
        .i_clk       (ck_1356megb),
        .i_rst       (reset),
        .i_adc_d     (adc_d),
        .i_threshold (threshold),
        .o_strobe    (w_strobe),
        .o_win_end   (w_win_end),
        .o_activity  (w_activity)
    );

    assign w_run       = trace_run(arm, major_mode);
    assign w_cnt_inc   = (r_count >= DEPTH_C) ? DEPTH_C : r_count + 12'd1;
    assign w_count_now = w_strobe && r_enable;

    always_ff @(negedge ck_1356megb or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_active <= 1'b0;
            r_full   <= 1'b0;
            r_count  <= '0;
            r_hold   <= '0;
        end else if (!w_run) begin
            // Full flag and count are left alone so the ARM can read them after stopping.
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                    r_full  <= 1'b0;
                    r_count <= '0;
                end
                ST_ARMED: begin
                    if (w_win_end && w_activity) begin
                        r_state  <= ST_ACTIVE;
                        r_enable <= 1'b1;
                        r_active <= 1'b1;
                    end
                end
                ST_ACTIVE, ST_HOLD: begin
                    if (w_count_now) begin
                        r_count <= w_cnt_inc;
                    end
                    if (w_count_now && oneshot && (w_cnt_inc == DEPTH_C)) begin
                        r_state  <= ST_FULL;
                        r_enable <= 1'b0;
                        r_active <= 1'b0;
                        r_full   <= 1'b1;
                    end else if (w_win_end) begin
                        if (w_activity) begin
                            r_state  <= ST_ACTIVE;
                            r_active <= 1'b1;
                        end else if (r_state == ST_ACTIVE) begin
                            r_state  <= ST_HOLD;
                            r_active <= 1'b0;
                            r_hold   <= HOLD_W'(HOLD_WIN - 1);
                        end else if (r_hold == '0) begin
                            r_state  <= ST_ARMED;
                            r_enable <= 1'b0;
                        end else begin
                            r_hold <= r_hold - HOLD_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    r_enable <= 1'b0;
                    r_active <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign trace_enable = r_enable;
    assign trace_active = r_active;
    assign trace_full   = r_full;
    assign sample_count = r_count;

endmodule

// File: tb/tb_hi_trace_trigger.sv
// Directed bench for hi_trace_trigger: edge indices count negedges since reset release,
// strobes fall on multiples of 8 and window ends on edges where index % 32 == 24.
module tb_hi_trace_trigger;
    import hi_trace_trigger_pkg::*;

    logic        clk = 1'b1;
    logic        reset;
    logic [7:0]  adc_d;
    logic [2:0]  major_mode;
    logic        arm;
    logic        oneshot;
    logic [7:0]  threshold;
    logic        trace_enable;
    logic        trace_active;
    logic        trace_full;
    logic [11:0] sample_count;

    int   nvec = 0;
    int   nerr = 0;
    int   ecnt = 0;
    bit   alt  = 1'b0;
    logic [7:0] lo   = 8'd100;
    logic [7:0] hi   = 8'd140;
    logic [7:0] cval = 8'd128;

    hi_trace_trigger dut (
        .ck_1356megb  (clk),
        .reset        (reset),
        .adc_d        (adc_d),
        .major_mode   (major_mode),
        .arm          (arm),
        .oneshot      (oneshot),
        .threshold    (threshold),
        .trace_enable (trace_enable),
        .trace_active (trace_active),
        .trace_full   (trace_full),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample for the upcoming edge: odd strobe index -> hi, even -> lo when alternating.
    task automatic cyc();
        if (alt) adc_d = (((ecnt / 8) % 2) == 1) ? hi : lo;
        else     adc_d = cval;
        @(negedge clk);
        @(posedge clk);
        ecnt++;
    endtask

    task automatic adv_to(input int target);
        while (ecnt < target) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        reset = 1'b0;
        ecnt  = 0;
    endtask

    function automatic int next_wend(input int e);
        int r;
        r = e % 32;
        return (r <= 24) ? (e + 24 - r) : (e + 56 - r);
    endfunction

    initial begin
        int e_w;
        reset      = 1'b1;
        arm        = 1'b0;
        oneshot    = 1'b0;
        major_mode = FPGA_MAJOR_MODE_OFF;
        threshold  = 8'd20;
        adc_d      = 8'd128;
        repeat (2) @(posedge clk);
        chk("rst_enable", 16'(trace_enable), 16'd0);
        chk("rst_active", 16'(trace_active), 16'd0);
        chk("rst_full",   16'(trace_full),   16'd0);
        chk("rst_count",  16'(sample_count), 16'd0);

        // Quiet carrier for 10 windows: stays armed.
        arm        = 1'b1;
        major_mode = FPGA_MAJOR_MODE_HF_READER;
        reset      = 1'b0;
        ecnt       = 0;
        adv_to(314);
        chk("quiet_enable", 16'(trace_enable), 16'd0);
        chk("quiet_active", 16'(trace_active), 16'd0);

        // 100/140 swing: window ending at edge 344 has span 40.
        alt = 1'b1; lo = 8'd100; hi = 8'd140;
        adv_to(345);
        chk("act_pre_enable", 16'(trace_enable), 16'd0);
        adv_to(346);
        chk("act_enable", 16'(trace_enable), 16'd1);
        chk("act_active", 16'(trace_active), 16'd1);
        adv_to(353);
        chk("act_first_count", 16'(sample_count), 16'd1);

        // Constant 128 from edge 416: first idle window ends at 440, 17th at 952.
        adv_to(409);
        alt = 1'b0;
        adv_to(442);
        chk("hold_enable", 16'(trace_enable), 16'd1);
        chk("hold_active", 16'(trace_active), 16'd0);
        adv_to(953);
        chk("hold_last_enable", 16'(trace_enable), 16'd1);
        adv_to(954);
        chk("hold_drop_enable", 16'(trace_enable), 16'd0);
        chk("hold_drop_count",  16'(sample_count), 16'd76);

        // One-shot: active again at 985, strobes from 992, DEPTH reached on edge 24952.
        oneshot = 1'b1;
        alt     = 1'b1;
        adv_to(24952);
        chk("os_pre_count",  16'(sample_count), 16'd3071);
        chk("os_pre_enable", 16'(trace_enable), 16'd1);
        adv_to(24953);
        chk("os_full_count",  16'(sample_count), 16'd3072);
        chk("os_full_flag",   16'(trace_full),   16'd1);
        chk("os_full_enable", 16'(trace_enable), 16'd0);
        chk("os_full_active", 16'(trace_active), 16'd0);
        adv_to(25053);
        chk("os_hold_count", 16'(sample_count), 16'd3072);
        chk("os_hold_flag",  16'(trace_full),   16'd1);

        // Disarm keeps the full flag; re-arm clears it.
        arm = 1'b0;
        cyc();
        chk("disarm_enable", 16'(trace_enable), 16'd0);
        chk("disarm_full",   16'(trace_full),   16'd1);
        arm     = 1'b1;
        oneshot = 1'b0;
        cyc();
        chk("rearm_full",  16'(trace_full),   16'd0);
        chk("rearm_count", 16'(sample_count), 16'd0);
        e_w = next_wend(ecnt);
        adv_to(e_w + 2);
        chk("rearm_active", 16'(trace_active), 16'd1);
        adv_to(e_w + 34);
        chk("rearm_count4", 16'(sample_count), 16'd4);

        // Switch to GET_TRACE while active: forced exit on the next edge.
        major_mode = FPGA_MAJOR_MODE_HF_GET_TRACE;
        cyc();
        chk("gt_enable", 16'(trace_enable), 16'd0);
        chk("gt_active", 16'(trace_active), 16'd0);
        chk("gt_full",   16'(trace_full),   16'd0);
        chk("gt_count",  16'(sample_count), 16'd4);
        major_mode = FPGA_MAJOR_MODE_HF_READER;
        cyc();
        chk("gt_rearm_count", 16'(sample_count), 16'd0);

        // Asynchronous reset in the middle of an active capture.
        e_w = next_wend(ecnt);
        adv_to(e_w + 18);
        chk("mid_enable", 16'(trace_enable), 16'd1);
        chk("mid_count",  16'(sample_count), 16'd2);
        #2 reset = 1'b1;
        #1;
        chk("async_enable", 16'(trace_enable), 16'd0);
        chk("async_count",  16'(sample_count), 16'd0);
        chk("async_active", 16'(trace_active), 16'd0);
        arm = 1'b0;
        @(posedge clk);
        @(posedge clk);
        reset = 1'b0;
        ecnt  = 0;
        adv_to(100);
        chk("idle_enable", 16'(trace_enable), 16'd0);
        chk("idle_active", 16'(trace_active), 16'd0);

        // threshold 0 with constant input: active after the first window (edge 24).
        arm = 1'b1; threshold = 8'd0; alt = 1'b0; cval = 8'd128;
        do_reset();
        adv_to(25);
        chk("thr0_pre_active", 16'(trace_active), 16'd0);
        adv_to(26);
        chk("thr0_active", 16'(trace_active), 16'd1);

        // threshold 255 with full-scale swing.
        threshold = 8'd255; alt = 1'b1; lo = 8'd0; hi = 8'd255;
        do_reset();
        adv_to(26);
        chk("thr255_full_active", 16'(trace_active), 16'd1);

        // threshold 255 with a swing one code short.
        hi = 8'd254;
        do_reset();
        adv_to(26);
        chk("thr255_short_active", 16'(trace_active), 16'd0);
        adv_to(90);
        chk("thr255_short_enable", 16'(trace_enable), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
